// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: pipe-register holds/flushes and PC redirect.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int PERF_W       = 32,
    parameter int BUS_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_busy,
    input  logic                 jump_req_ex,
    input  logic [BUS_WIDTH-1:0] jump_addr_ex,
    input  logic                 load_use_id,
    output logic                 hold_pc,
    output logic                 hold_if_id,
    output logic                 hold_id_ex,
    output logic                 hold_ex_mem,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 redirect_valid,
    output logic [BUS_WIDTH-1:0] redirect_pc,
    output logic [PERF_W-1:0]    perf_stall_cnt,
    output logic [PERF_W-1:0]    perf_flush_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, LU_STALL, FLUSH} state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [2:0] flush_cnt, flush_cnt_nxt;

    always_comb begin
        state_nxt      = state;
        flush_cnt_nxt  = flush_cnt;
        hold_pc        = 1'b0;
        hold_if_id     = 1'b0;
        hold_id_ex     = 1'b0;
        hold_ex_mem    = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state)
            RUN, LU_STALL: begin
                if (mem_busy) begin
                    {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem} = 4'hf;
                    state_nxt = MEM_WAIT;
                end else if (jump_req_ex) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = jump_addr_ex;
                    flush_if_id    = 1'b1;
                    flush_id_ex    = 1'b1;
                    flush_cnt_nxt  = FLUSH_LOAD;
                    state_nxt      = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                // A load-use seen right after its own bubble is covered by forwarding.
                end else if (load_use_id && state == RUN) begin
                    hold_pc     = 1'b1;
                    hold_if_id  = 1'b1;
                    flush_id_ex = 1'b1;
                    state_nxt   = LU_STALL;
                end else begin
                    state_nxt = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_busy) begin
                    {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem} = 4'hf;
                end else begin
                    state_nxt = RUN;
                end
            end
            FLUSH: begin
                // The count keeps running under mem_busy; if_id flush overrides its hold.
                flush_if_id   = 1'b1;
                flush_cnt_nxt = flush_cnt - 3'd1;
                if (mem_busy) begin
                    {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem} = 4'hf;
                end
                if (flush_cnt <= 3'd1) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
        if (!rst_n) begin
            hold_pc        = 1'b0;
            hold_if_id     = 1'b0;
            hold_id_ex     = 1'b0;
            hold_ex_mem    = 1'b0;
            flush_if_id    = 1'b0;
            flush_id_ex    = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            flush_cnt <= 3'd0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] redir_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (hold_pc) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
            if (redirect_valid) begin
                redir_cnt_q <= redir_cnt_q + PERF_W'(1);
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = redir_cnt_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized self-checking bench for pipe_ctrl against a cycle-level behavioural model.
// Perf-counter expectations follow PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

    localparam int FC = 2;
    localparam int BW = 32;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_busy = 1'b0;
    logic          jump_req_ex = 1'b0;
    logic [BW-1:0] jump_addr_ex = '0;
    logic          load_use_id = 1'b0;
    logic          hold_pc, hold_if_id, hold_id_ex, hold_ex_mem;
    logic          flush_if_id, flush_id_ex, redirect_valid;
    logic [BW-1:0] redirect_pc;
    logic [PW-1:0] perf_stall_cnt, perf_flush_cnt;

    pipe_ctrl #(.FLUSH_CYCLES(FC), .PERF_W(PW), .BUS_WIDTH(BW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_busy       (mem_busy),
        .jump_req_ex    (jump_req_ex),
        .jump_addr_ex   (jump_addr_ex),
        .load_use_id    (load_use_id),
        .hold_pc        (hold_pc),
        .hold_if_id     (hold_if_id),
        .hold_id_ex     (hold_id_ex),
        .hold_ex_mem    (hold_ex_mem),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    always #5 clk = ~clk;

    logic [6:0] ctl;
    assign ctl = {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, flush_if_id, flush_id_ex, redirect_valid};

    int n_tests = 0;
    int n_fail  = 0;

    // Model: remaining if_id flush cycles, memory-wait flag, bubble-just-inserted flag, event totals.
    int          m_flush_left;
    bit          m_mem_wait;
    bit          m_lu_prev;
    int unsigned m_stall;
    int unsigned m_redir;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flush_left = 0;
        m_mem_wait   = 1'b0;
        m_lu_prev    = 1'b0;
        m_stall      = 0;
        m_redir      = 0;
    endtask

    task automatic check_perf();
`ifdef PIPE_CTRL_PERF_EN
        chk("stall_cnt", 64'(perf_stall_cnt), 64'(m_stall));
        chk("flush_cnt", 64'(perf_flush_cnt), 64'(m_redir));
`else
        chk("stall_cnt", 64'(perf_stall_cnt), 64'd0);
        chk("flush_cnt", 64'(perf_flush_cnt), 64'd0);
`endif
    endtask

    // Entered just after a rising edge; applies inputs, checks before the next edge, advances model.
    task automatic cycle(input bit mb, input bit jr, input bit lu, input logic [BW-1:0] addr);
        logic [6:0]    e;
        logic [BW-1:0] epc;
        bit            lu_next;
        mem_busy     = mb;
        jump_req_ex  = jr;
        load_use_id  = lu;
        jump_addr_ex = addr;
        e       = '0;
        epc     = '0;
        lu_next = 1'b0;
        if (m_flush_left > 0) begin
            e[2] = 1'b1;
            if (mb) e[6:3] = 4'hf;
            m_flush_left--;
        end else if (m_mem_wait) begin
            if (mb) e[6:3] = 4'hf;
            else    m_mem_wait = 1'b0;
        end else if (mb) begin
            e[6:3]     = 4'hf;
            m_mem_wait = 1'b1;
        end else if (jr) begin
            e[2:0]       = 3'b111;
            epc          = addr;
            m_flush_left = FC - 1;
        end else if (lu && !m_lu_prev) begin
            e[6]    = 1'b1;
            e[5]    = 1'b1;
            e[1]    = 1'b1;
            lu_next = 1'b1;
        end
        m_lu_prev = lu_next;
        @(negedge clk);
        chk("ctl", 64'(ctl), 64'(e));
        chk("redirect_pc", 64'(redirect_pc), 64'(epc));
        check_perf();
        m_stall += 32'(e[6]);
        m_redir += 32'(e[0]);
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        // Outputs must stay 0 under reset even with live requests.
        mem_busy    = 1'b1;
        jump_req_ex = 1'b1;
        load_use_id = 1'b1;
        #2;
        chk("rst_ctl", 64'(ctl), 64'd0);
        chk("rst_pc", 64'(redirect_pc), 64'd0);
        mem_busy    = 1'b0;
        jump_req_ex = 1'b0;
        load_use_id = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        cycle(0, 0, 0, '0);
        cycle(0, 0, 0, '0);
        // Memory wait of three cycles, then release.
        cycle(1, 0, 0, '0);
        cycle(1, 0, 0, '0);
        cycle(1, 0, 0, '0);
        cycle(0, 0, 0, '0);
        // Redirect to 0x80.
        cycle(0, 1, 0, 32'h0000_0080);
        cycle(0, 0, 0, '0);
        cycle(0, 0, 0, '0);
        // Load-use held for two cycles gives a single bubble.
        cycle(0, 0, 1, '0);
        cycle(0, 0, 1, '0);
        cycle(0, 0, 0, '0);
        // Memory wait and jump together.
        cycle(1, 1, 0, 32'h0000_0400);
        cycle(1, 1, 0, 32'h0000_0400);
        cycle(0, 1, 0, 32'h0000_0400);
        cycle(0, 1, 0, 32'h0000_0400);
        cycle(0, 0, 0, '0);
        cycle(0, 0, 0, '0);
        // mem_busy inside the flush window.
        cycle(0, 1, 0, 32'h0000_1000);
        cycle(1, 0, 0, '0);
        cycle(1, 0, 0, '0);
        cycle(0, 0, 0, '0);

        // Reset pulse while in FLUSH.
        cycle(0, 1, 0, 32'h0000_2000);
        rst_n = 1'b0;
        #1;
        chk("rst_in_flush_ctl", 64'(ctl), 64'd0);
        chk("rst_in_flush_pc", 64'(redirect_pc), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cycle(0, 0, 0, '0);
        chk("no_residual_flush", 64'(flush_if_id), 64'd0);
        cycle(0, 0, 0, '0);

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) == 0, BW'($urandom));
        end
        cycle(0, 0, 0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
